// File: rtl/oam_dma_arbiter_if.sv
// -----------------------------------------------------------------------------
// oam_dma_arbiter_if
// Groups the core-side and system-side bus signals of the OAM DMA arbiter.
//   cpu_addr/cpu_rw/cpu_dout : core request (cpu_rw 1 = read)
//   cpu_din/cpu_rdy          : read data and advance enable back to the core
//   bus_addr/bus_rw/bus_dout : system bus request
//   bus_din                  : system read data
//   busy                     : DMA owns or is acquiring the bus
//   dmc_* (DMC_DMA_EN only)  : single-byte sample-fetch requester
// Modports: slave = arbiter side, master = core/system environment side.
// -----------------------------------------------------------------------------
interface oam_dma_arbiter_if;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic [15:0] bus_addr;
    logic        bus_rw;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;
    logic        busy;
`ifdef DMC_DMA_EN
    logic        dmc_req;
    logic [15:0] dmc_addr;
    logic        dmc_ack;
    logic [7:0]  dmc_data;

    modport slave (
        input  cpu_addr, cpu_rw, cpu_dout, bus_din, dmc_req, dmc_addr,
        output cpu_din, cpu_rdy, bus_addr, bus_rw, bus_dout, busy, dmc_ack, dmc_data
    );
    modport master (
        output cpu_addr, cpu_rw, cpu_dout, bus_din, dmc_req, dmc_addr,
        input  cpu_din, cpu_rdy, bus_addr, bus_rw, bus_dout, busy, dmc_ack, dmc_data
    );
`else
    modport slave (
        input  cpu_addr, cpu_rw, cpu_dout, bus_din,
        output cpu_din, cpu_rdy, bus_addr, bus_rw, bus_dout, busy
    );
    modport master (
        output cpu_addr, cpu_rw, cpu_dout, bus_din,
        input  cpu_din, cpu_rdy, bus_addr, bus_rw, bus_dout, busy
    );
`endif
endinterface

// File: rtl/oam_dma_arbiter.sv
// -----------------------------------------------------------------------------
// oam_dma_arbiter
// Owns the CPU external bus and shares it between the 6502 core and the
// sprite-DMA engine. A core write to DMA_REG halts the core (cpu_rdy=0) and
// copies page $XX00..$XXFF to OAM_DATA as alternating get(read)/put(write)
// cycles, then returns the bus to the core.
// Ports:
//   clk   : system clock, one CPU cycle per clk
//   reset : synchronous, active-high
//   io    : oam_dma_arbiter_if.slave (cpu_*, bus_*, busy, optional dmc_*)
// Optional feature macro: DMC_DMA_EN adds a one-byte DMC sample fetch that
// pre-empts sprite DMA at the next get cycle.
// -----------------------------------------------------------------------------
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [15:0] OAM_DATA = 16'h2004
) (
    input  logic              clk,
    input  logic              reset,
    oam_dma_arbiter_if.slave  io
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
`ifdef DMC_DMA_EN
        ST_WRITE = 3'd4,
        ST_DMC   = 3'd5
`else
        ST_WRITE = 3'd4
`endif
    } state_t;

    state_t      state_q, state_d;
    state_t      fetch_st_s;
    logic        put_q;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] bus_addr_s;
    logic        bus_rw_s;
    logic [7:0]  bus_dout_s;
`ifdef DMC_DMA_EN
    logic        pend_q, pend_d;
    logic        sprite_q, sprite_d;
    logic        dmc_ack_q;
    logic [7:0]  dmc_data_q;
`endif

    // State entered whenever a get cycle is due: a pending DMC fetch wins over
    // the next sprite read.
`ifdef DMC_DMA_EN
    assign fetch_st_s = pend_q ? ST_DMC : ST_READ;
`else
    assign fetch_st_s = ST_READ;
`endif

    // Next-state and datapath-register logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        byte_d  = byte_q;
`ifdef DMC_DMA_EN
        sprite_d = sprite_q;
        // A request arriving while one is pending merges into it; the fetch
        // cycle itself clears the flag.
        if (state_q == ST_DMC) begin
            pend_d = 1'b0;
        end else if (io.dmc_req) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (!io.cpu_rw && (io.cpu_addr == DMA_REG)) begin
                    page_d  = io.cpu_dout;
                    state_d = ST_HALT;
`ifdef DMC_DMA_EN
                    sprite_d = 1'b1;
                end else if (pend_q) begin
                    state_d = ST_HALT;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                // Core writes are not stoppable by RDY; wait for the first
                // read (the halt cycle). A put now means the next cycle is a
                // get, so no alignment cycle is needed.
                if (io.cpu_rw) begin
                    state_d = put_q ? fetch_st_s : ST_ALIGN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_ALIGN: begin
                state_d = fetch_st_s;
            end
            ST_READ: begin
                byte_d  = io.bus_din;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (idx_q == 8'hFF) begin
                    idx_d = 8'h00;
`ifdef DMC_DMA_EN
                    sprite_d = 1'b0;
                    state_d  = pend_q ? ST_DMC : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = fetch_st_s;
                end
            end
`ifdef DMC_DMA_EN
            ST_DMC: begin
                // An interrupted sprite transfer needs one put cycle before
                // its read can resume on a get cycle.
                state_d = sprite_q ? ST_ALIGN : ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus multiplexer: the core drives the bus unless DMA owns the cycle.
    always_comb begin
        bus_addr_s = io.cpu_addr;
        bus_rw_s   = io.cpu_rw;
        bus_dout_s = io.cpu_dout;
        case (state_q)
            ST_ALIGN: begin
                bus_rw_s = 1'b1;
            end
            ST_READ: begin
                bus_addr_s = {page_q, idx_q};
                bus_rw_s   = 1'b1;
            end
            ST_WRITE: begin
                bus_addr_s = OAM_DATA;
                bus_rw_s   = 1'b0;
                bus_dout_s = byte_q;
            end
`ifdef DMC_DMA_EN
            ST_DMC: begin
                bus_addr_s = io.dmc_addr;
                bus_rw_s   = 1'b1;
            end
`endif
            default: begin
                bus_addr_s = io.cpu_addr;
                bus_rw_s   = io.cpu_rw;
                bus_dout_s = io.cpu_dout;
            end
        endcase
    end

    assign io.bus_addr = bus_addr_s;
    assign io.bus_rw   = bus_rw_s;
    assign io.bus_dout = bus_dout_s;
    assign io.cpu_din  = io.bus_din;
    assign io.cpu_rdy  = (state_q == ST_IDLE);
    assign io.busy     = (state_q != ST_IDLE);
`ifdef DMC_DMA_EN
    assign io.dmc_ack  = dmc_ack_q;
    assign io.dmc_data = dmc_data_q;
`endif

    // State, get/put parity and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            put_q   <= 1'b0;
            idx_q   <= 8'h00;
            page_q  <= 8'h00;
            byte_q  <= 8'h00;
`ifdef DMC_DMA_EN
            pend_q     <= 1'b0;
            sprite_q   <= 1'b0;
            dmc_ack_q  <= 1'b0;
            dmc_data_q <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            put_q   <= ~put_q;
            idx_q   <= idx_d;
            page_q  <= page_d;
            byte_q  <= byte_d;
`ifdef DMC_DMA_EN
            pend_q    <= pend_d;
            sprite_q  <= sprite_d;
            dmc_ack_q <= (state_q == ST_DMC);
            if (state_q == ST_DMC) begin
                dmc_data_q <= io.bus_din;
            end else begin
                dmc_data_q <= dmc_data_q;
            end
`endif
        end
    end

endmodule
